// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding/hazard unit: scoreboard entry
// layout, select-code names and the select-width helper.
package fwd_pkg;

    // Widest register index a scoreboard entry can hold; REG_ADDR_W must not exceed it.
    localparam int unsigned RD_W_MAX = 8;

    localparam int unsigned FWD_NONE = 32'd0;
    localparam int unsigned FWD_MEM  = 32'd2;
    localparam int unsigned FWD_WB   = 32'd3;

    typedef struct packed {
        logic                v;
        logic                wr;
        logic                ld;
        logic [RD_W_MAX-1:0] rd;
    } sb_entry_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage decode inputs and forwarding/stall outputs of the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CNT_W      = 16
);
    logic                  fwdEN;
    logic                  freeze;
    logic                  flush;
    logic                  valid_ID;
    logic                  RegWrite_ID;
    logic                  MemRead_ID;
    logic [REG_ADDR_W-1:0] rd_ID;
    logic [REG_ADDR_W-1:0] Rn_ID;
    logic [REG_ADDR_W-1:0] Rm_ID;
    logic                  useRn_ID;
    logic                  useRm_ID;
    logic                  stall;
    logic [SEL_W-1:0]      FWDA;
    logic [SEL_W-1:0]      FWDB;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output fwdEN, freeze, flush, valid_ID, RegWrite_ID, MemRead_ID,
               rd_ID, Rn_ID, Rm_ID, useRn_ID, useRm_ID,
        input  stall, FWDA, FWDB, stall_count
    );

    modport slave (
        input  fwdEN, freeze, flush, valid_ID, RegWrite_ID, MemRead_ID,
               rd_ID, Rn_ID, Rm_ID, useRn_ID, useRm_ID,
        output stall, FWDA, FWDB, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Youngest-producer search for one ID source operand across the scoreboard.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                  use_i,
    input  logic [REG_ADDR_W-1:0] src_i,
    input  sb_entry_t [DEPTH:1]   sb_i,
    output logic                  hit_o,
    output logic [SEL_W-1:0]      stage_o,
    output logic                  load_o
);

    // Walk oldest to youngest so the lowest matching stage is the one left standing.
    always_comb begin
        hit_o   = 1'b0;
        stage_o = '0;
        load_o  = 1'b0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (use_i && (src_i != REG_ADDR_W'(ZERO_REG)) && (s <= int'(DEPTH) - 1) &&
                sb_i[s].v && sb_i[s].wr && (sb_i[s].rd == RD_W_MAX'(src_i))) begin
                hit_o   = 1'b1;
                stage_o = SEL_W'(s);
                load_o  = sb_i[s].ld;
            end else begin
                hit_o   = hit_o;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: in-flight destination scoreboard, registered EX
// operand selects, load-use/interlock stall and a saturating stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned CNT_W      = 16
) (
    input logic              clk,
    input logic              reset,
    fwd_hazard_unit_if.slave bus
);

    localparam int unsigned SEL_W = sel_width(DEPTH);

    sb_entry_t [DEPTH:1] sb_q, sb_d;
    sb_entry_t           id_entry;
    logic [SEL_W-1:0]    fwda_q, fwdb_q, fwda_d, fwdb_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                hit_a, hit_b, ld_a, ld_b;
    logic [SEL_W-1:0]    stage_a, stage_b;
    logic                hazard, stall, bubble;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rn (
        .use_i(bus.useRn_ID), .src_i(bus.Rn_ID), .sb_i(sb_q),
        .hit_o(hit_a), .stage_o(stage_a), .load_o(ld_a)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rm (
        .use_i(bus.useRm_ID), .src_i(bus.Rm_ID), .sb_i(sb_q),
        .hit_o(hit_b), .stage_o(stage_b), .load_o(ld_b)
    );

    // Turn each operand's producer into a select or a stall request.
    always_comb begin
        hazard = 1'b0;
        fwda_d = SEL_W'(FWD_NONE);
        fwdb_d = SEL_W'(FWD_NONE);
        if (hit_a) begin
            if (!bus.fwdEN || (ld_a && ((32'(stage_a) + 32'd1) < LOAD_READY))) begin
                hazard = 1'b1;
            end else begin
                fwda_d = stage_a + SEL_W'(1);
            end
        end else begin
            fwda_d = SEL_W'(FWD_NONE);
        end
        if (hit_b) begin
            if (!bus.fwdEN || (ld_b && ((32'(stage_b) + 32'd1) < LOAD_READY))) begin
                hazard = 1'b1;
            end else begin
                fwdb_d = stage_b + SEL_W'(1);
            end
        end else begin
            fwdb_d = SEL_W'(FWD_NONE);
        end
    end

    assign stall  = hazard && bus.valid_ID && !bus.flush;
    assign bubble = stall || bus.flush || !bus.valid_ID;

    // Next scoreboard: age every entry one stage, ID entry (or a bubble) enters EX.
    always_comb begin
        id_entry = '0;
        if (!bubble) begin
            id_entry.v  = 1'b1;
            id_entry.wr = bus.RegWrite_ID;
            id_entry.ld = bus.MemRead_ID;
            id_entry.rd = RD_W_MAX'(bus.rd_ID);
        end else begin
            id_entry = '0;
        end
        sb_d = sb_q;
        for (int k = DEPTH; k >= 2; k--) begin
            sb_d[k] = sb_q[k-1];
        end
        sb_d[1] = id_entry;
    end

    // Pipeline state advances only on unfrozen edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q   <= '0;
            fwda_q <= '0;
            fwdb_q <= '0;
            cnt_q  <= '0;
        end else if (!bus.freeze) begin
            sb_q   <= sb_d;
            fwda_q <= bubble ? SEL_W'(FWD_NONE) : fwda_d;
            fwdb_q <= bubble ? SEL_W'(FWD_NONE) : fwdb_d;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
        end else begin
            sb_q <= sb_q;
        end
    end

    assign bus.stall       = stall;
    assign bus.FWDA        = fwda_q;
    assign bus.FWDB        = fwdb_q;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed table-driven bench for fwd_hazard_unit plus a freeze/reset sequence.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int unsigned SEL_W = sel_width(3);

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fwd_hazard_unit_if #(.REG_ADDR_W(5), .SEL_W(SEL_W), .CNT_W(16)) bus ();

    fwd_hazard_unit #(
        .REG_ADDR_W(5), .ZERO_REG(31), .DEPTH(3), .LOAD_READY(3), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit en; bit fl;
        bit v; bit w; bit ld;
        int rd; int rn; int rm;
        bit un; bit um;
        bit x_stall; int x_a; int x_b; int x_cnt;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(bit rst, bit en, bit fl, bit v, bit w, bit ld,
                                int rd, int rn, int rm, bit un, bit um,
                                bit xs, int xa, int xb, int xc);
        vec_t t;
        t.rst = rst; t.en = en; t.fl = fl; t.v = v; t.w = w; t.ld = ld;
        t.rd = rd; t.rn = rn; t.rm = rm; t.un = un; t.um = um;
        t.x_stall = xs; t.x_a = xa; t.x_b = xb; t.x_cnt = xc;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit w, input bit ld, input int rd,
                         input int rn, input int rm, input bit un, input bit um);
        bus.valid_ID    = v;
        bus.RegWrite_ID = w;
        bus.MemRead_ID  = ld;
        bus.rd_ID       = 5'(rd);
        bus.Rn_ID       = 5'(rn);
        bus.Rm_ID       = 5'(rm);
        bus.useRn_ID    = un;
        bus.useRm_ID    = um;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_regs(input string tag, input int a, input int b, input int c);
        chk({tag, ".FWDA"}, int'(bus.FWDA), a);
        chk({tag, ".FWDB"}, int'(bus.FWDB), b);
        chk({tag, ".cnt"}, int'(bus.stall_count), c);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; total = 0; bad = 0;
        bus.fwdEN = 1'b1; bus.freeze = 1'b0; bus.flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        //            rst en fl v  w  ld rd  rn  rm un um  stall A  B  cnt
        vecs[0]  = mk(1, 1, 0, 1, 1, 0,  1,  2,  3, 1, 1,  0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 1, 1, 0,  2,  1,  3, 1, 1,  0, 2, 0, 0);
        vecs[2]  = mk(1, 1, 0, 1, 1, 0,  1,  2,  3, 1, 1,  0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 1, 1, 0,  4,  5,  1, 1, 1,  0, 0, 3, 0);
        vecs[5]  = mk(1, 1, 0, 1, 1, 1,  9,  2,  0, 1, 0,  0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 1, 1, 0, 10,  9,  9, 1, 1,  1, 0, 0, 1);
        vecs[7]  = mk(0, 1, 0, 1, 1, 0, 10,  9,  9, 1, 1,  0, 3, 3, 1);
        vecs[8]  = mk(1, 1, 0, 1, 1, 0, 31,  1,  2, 1, 1,  0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 0, 1, 1, 1, 31,  2,  0, 1, 0,  0, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 1, 1, 0,  2, 31, 31, 1, 1,  0, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 1, 1, 0,  1,  5,  6, 1, 1,  0, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 1, 1, 0,  1,  5,  6, 1, 1,  0, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 1, 1, 0,  2,  1,  1, 1, 1,  0, 2, 2, 0);
        vecs[14] = mk(1, 0, 0, 1, 1, 0,  1,  5,  6, 1, 1,  0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 1, 0,  2,  1,  3, 1, 1,  1, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 1, 1, 0,  2,  1,  3, 1, 1,  1, 0, 0, 2);
        vecs[17] = mk(0, 0, 0, 1, 1, 0,  2,  1,  3, 1, 1,  0, 0, 0, 2);
        vecs[18] = mk(1, 0, 0, 1, 1, 0,  1,  5,  6, 1, 1,  0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 1, 1, 0,  2,  1,  3, 1, 1,  1, 0, 0, 1);
        vecs[20] = mk(0, 0, 1, 1, 1, 0,  2,  1,  3, 1, 1,  0, 0, 0, 1);
        vecs[21] = mk(0, 0, 0, 1, 1, 0,  2,  1,  3, 1, 1,  0, 0, 0, 1);

        #2;
        chk("reset.stall", int'(bus.stall), 0);
        chk_regs("reset", 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clk);
            bus.fwdEN = vecs[i].en;
            bus.flush = vecs[i].fl;
            drive(vecs[i].v, vecs[i].w, vecs[i].ld, vecs[i].rd, vecs[i].rn,
                  vecs[i].rm, vecs[i].un, vecs[i].um);
            #1;
            chk($sformatf("v%0d.stall", i), int'(bus.stall), int'(vecs[i].x_stall));
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), vecs[i].x_a, vecs[i].x_b, vecs[i].x_cnt);
        end

        // Freeze mid-hazard, then asynchronous reset while the stall is pending.
        do_reset();
        bus.fwdEN = 1'b1;
        bus.flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 9, 5, 0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1, 9, 6, 1'b1, 1'b1);
        #1 chk("seq.c1.stall", int'(bus.stall), 1);
        @(posedge clk);
        #1 chk_regs("seq.c1", 0, 0, 1);
        @(negedge clk);
        #1 chk("seq.c2.stall", int'(bus.stall), 0);
        @(posedge clk);
        #1 chk_regs("seq.c2", FWD_WB, 0, 1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 7, 1, 0, 1'b1, 1'b0);
        #1 chk("seq.c3.stall", int'(bus.stall), 0);
        @(posedge clk);
        #1 chk_regs("seq.c3", FWD_MEM, 0, 1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8, 7, 7, 1'b1, 1'b1);
        bus.freeze = 1'b1;
        for (int f = 0; f < 3; f++) begin
            #1 chk($sformatf("frz%0d.stall", f), int'(bus.stall), 1);
            @(posedge clk);
            #1 chk_regs($sformatf("frz%0d", f), FWD_MEM, 0, 1);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        chk("arst.stall", int'(bus.stall), 0);
        chk_regs("arst", 0, 0, 0);
        @(negedge clk);
        reset      = 1'b0;
        bus.freeze = 1'b0;
        #1 chk("post.stall", int'(bus.stall), 0);
        @(posedge clk);
        #1 chk_regs("post", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined ARM core.
- Keeps an internal scoreboard of in-flight destination registers, one entry per tracked stage after ID (EX, MEM, WB by default).
- From that scoreboard it produces registered per-operand forwarding selects for EX, a load-use/interlock stall for ID, and a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline register and is driven from the ID-stage decode.

Parameters:
- REG_ADDR_W, 5: register index width.
- ZERO_REG, 31: index of XZR; never forwarded, never causes a stall.
- DEPTH, 3: number of tracked stages after ID. Stage 1 is EX, stage DEPTH is WB.
- LOAD_READY, 3: first stage whose pipeline-register output carries load data.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- fwdEN  in  1  1 selects forwarding mode; 0 selects pure-interlock mode.
- freeze  in  1  global pipeline freeze (memory wait).
- flush  in  1  squash the ID instruction (branch taken).
- valid_ID  in  1  ID holds a real instruction.
- RegWrite_ID  in  1  ID instruction writes rd_ID.
- MemRead_ID  in  1  ID instruction is a load.
- rd_ID  in  REG_ADDR_W  ID destination register.
- Rn_ID, Rm_ID  in  REG_ADDR_W each  ID source operands.
- useRn_ID, useRm_ID  in  1 each  operand actually read.
- stall  out  1  hold PC and IF/ID, insert a bubble into EX (combinational).
- FWDA, FWDB  out  SEL_W each  EX operand mux selects, registered. SEL_W = $clog2(DEPTH+1).
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- **Scoreboard.** Entries e[1..DEPTH], each holding {v, wr, ld, rd}.
- **Shift.** On each clk edge with freeze=0:
  - e[k+1] <= e[k] for k = 1..DEPTH-1.
  - e[1] <= ID entry, or a bubble (v=0) if stall=1, flush=1 or valid_ID=0.
  - The entry leaving stage DEPTH is dropped. The register file writes first-half/reads second-half, so no select is needed for it.
- **Match.** Source S in ID matches entry e[s] when all of the following hold: use bit set, S != ZERO_REG, e[s].v, e[s].wr, e[s].rd == S, and s <= DEPTH-1.
- **Youngest wins.** The lowest s that matches is the producer.
- **Select computation (fwdEN=1).**
  - Producer is a non-load at e[s]: next select = s+1.
  - Producer is a load with s+1 >= LOAD_READY: next select = s+1.
  - Producer is a load with s+1 < LOAD_READY: stall=1.
  - No producer: select = 0.
  - Code k means "take the stage-k pipeline-register result". For default DEPTH=3: 2 = EX/MEM, 3 = MEM/WB.
- **Interlock mode (fwdEN=0).** Any match gives stall=1. Selects are always 0.
- **Select register.** FWDA/FWDB load the next select on each unfrozen edge. They load 0 when a bubble enters EX (stall, flush or invalid). Latency: computed in ID, valid for the same instruction in EX one cycle later.
- **stall.** Combinational. Forced to 0 when flush=1 or valid_ID=0. freeze does not mask it.
- **stall_count.** Increments on each unfrozen edge with stall=1 and saturates at all-ones.
- **freeze=1.** Scoreboard, FWDA, FWDB and stall_count all hold.
- **Reset.** All entries v=0, FWDA=FWDB=0, stall_count=0, so stall=0. Reset asserted mid-stall clears the stall on the next evaluation. Reset takes precedence over freeze and flush.
- **Simultaneous events.** flush together with a hazard gives no stall, and a bubble is inserted. Rn==Rm gives identical FWDA and FWDB.

Decomposition:
- Package fwd_pkg holds:
  - typedef sb_entry_t {v, wr, ld, rd};
  - localparam function for SEL_W;
  - named select constants FWD_NONE=0, FWD_MEM=2, FWD_WB=3.
- One sub-module, fwd_match: combinational youngest-match search for a single source operand, returning {hit, stage, is_load}. It is instantiated twice, for Rn and Rm.

Test Plan:
1. Reset, then ADD X1 followed by SUB X2,X1,X3 → no stall. The cycle after SUB issues: FWDA=2, FWDB=0.
2. ADD X1, NOP, ORR X4,X5,X1 → FWDA=0, FWDB=3.
3. LDUR X9 followed by ADD X10,X9,X9 → stall=1 for exactly 1 cycle and stall_count=1. After the bubble, FWDA=FWDB=3.
4. Writes to X31 followed by a read of X31 → no stall, selects 0. ADD X1;ADD X1;SUB X2,X1,X1 → FWDA=FWDB=2 (youngest wins).
5. With fwdEN=0, ADD X1;SUB X2,X1,X3 → stall held 2 cycles, selects 0, stall_count=2. Assert flush during a stall → stall drops to 0 that cycle.
6. freeze=1 for 3 cycles mid-hazard → outputs and stall_count hold. Reset pulse mid-stall → all outputs 0 asynchronously.
